// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder
//   Turns an encoded winner index into a registered one-hot grant and holds it
//   until the granted agent acknowledges on its done line or the hold timer
//   runs out. Each grant is followed by one dead cycle before the next accept.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_idx       encoded index (sampled only on in_valid & in_ready)
//   in_valid     in_idx is meaningful
//   in_ready     decoder can accept; transfer = in_valid & in_ready
//   grant        one-hot grant, registered
//   done         per-line acknowledge; only the line currently granted is used
//   busy         high in any state other than IDLE
//   timeout_err  one-cycle pulse when a grant is dropped by the hold timer
//   bad_idx      one-cycle pulse when an out-of-range index was offered
//   hold_cnt     cycles the current grant has been held (0 on first cycle)
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the state register, never
// on in_valid, so upstream may hold in_valid high as long as it likes.

module onehot_grant_decoder #(
    parameter int N       = 4,
    parameter int IDXW    = $clog2(N),
    parameter int TIMEOUT = 16,
    parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] in_idx,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N-1:0]    grant,
    input  logic [N-1:0]    done,
    output logic            busy,
    output logic            timeout_err,
    output logic            bad_idx,
    output logic [CNTW-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [IDXW:0]   N_EXT     = (IDXW + 1)'(N);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_SAT   = CNTW'(TIMEOUT);

    state_t          state, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    grant_d;
    logic [N-1:0]    onehot;
    logic [CNTW-1:0] cnt_d;
    logic            to_d;
    logic            bad_d;
    logic            accept;
    logic            idx_ok;
    logic            line_done;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    // Widen by one bit so the range check is meaningful when N is a power of 2.
    assign idx_ok    = ({1'b0, in_idx} < N_EXT);
    assign line_done = done[idx_q];

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (in_idx == IDXW'(i));
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        grant_d = grant;
        cnt_d   = hold_cnt;
        to_d    = 1'b0;
        bad_d   = 1'b0;
        case (state)
            IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                if (accept) begin
                    if (idx_ok) begin
                        idx_d   = in_idx;
                        grant_d = onehot;
                        state_d = GRANT;
                    end else begin
                        // Out-of-range index is consumed without a grant.
                        bad_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                // done has priority over the timer expiring in the same cycle.
                if (line_done) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (hold_cnt == CNT_LAST) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = RELEASE;
                end else if (hold_cnt != CNT_SAT) begin
                    cnt_d = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx_q       <= '0;
            grant       <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            bad_idx     <= 1'b0;
        end else begin
            state       <= state_d;
            idx_q       <= idx_d;
            grant       <= grant_d;
            hold_cnt    <= cnt_d;
            timeout_err <= to_d;
            bad_idx     <= bad_d;
        end
    end

endmodule

// File: tb/tb_onehot_grant_decoder.sv
module tb_onehot_grant_decoder;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic [1:0] in_idx = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] grant;
    logic [3:0] done = '0;
    logic       busy, timeout_err, bad_idx;
    logic [4:0] hold_cnt;

    // N=5 instance (non power of two, exercises bad_idx)
    logic [2:0] idx5 = '0;
    logic       valid5 = 1'b0;
    logic       ready5;
    logic [4:0] grant5;
    logic [4:0] done5 = '0;
    logic       busy5, to5, bad5;
    logic [4:0] hc5;

    onehot_grant_decoder #(.N(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
        .in_ready(in_ready), .grant(grant), .done(done), .busy(busy),
        .timeout_err(timeout_err), .bad_idx(bad_idx), .hold_cnt(hold_cnt)
    );

    onehot_grant_decoder #(.N(5), .TIMEOUT(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_idx(idx5), .in_valid(valid5),
        .in_ready(ready5), .grant(grant5), .done(done5), .busy(busy5),
        .timeout_err(to5), .bad_idx(bad5), .hold_cnt(hc5)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (N=4 instance) ----------------
    // phase: 0 waiting for a request, 1 a line is granted, 2 dead cycle.
    int m_phase = 0;
    int m_line  = 0;
    int m_age   = 0;
    bit m_to    = 0;
    bit m_bad   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_line = 0; m_age = 0; m_to = 0; m_bad = 0;
        end else begin
            m_to  = 0;
            m_bad = 0;
            if (m_phase == 0) begin
                if (in_valid) begin
                    if (int'(in_idx) < N) begin
                        m_line = int'(in_idx); m_age = 0; m_phase = 1;
                    end else begin
                        m_bad = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (done[m_line]) begin
                    m_phase = 2; m_age = 0;
                end else if (m_age == TIMEOUT - 1) begin
                    m_phase = 2; m_age = 0; m_to = 1;
                end else begin
                    m_age = m_age + 1;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // One compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("cmp_grant", 32'(grant), (m_phase == 1) ? (32'd1 << m_line) : 32'd0);
        check("cmp_hold_cnt", 32'(hold_cnt), (m_phase == 1) ? 32'(m_age) : 32'd0);
        check("cmp_busy", 32'(busy), 32'(m_phase != 0));
        check("cmp_in_ready", 32'(in_ready), 32'(m_phase == 0));
        check("cmp_timeout_err", 32'(timeout_err), 32'(m_to));
        check("cmp_bad_idx", 32'(bad_idx), 32'(m_bad));
    end

    // ---------------- driver tasks ----------------
    // Offers idx for one cycle; returns at the falling edge of the first grant cycle.
    task automatic accept4(input logic [1:0] idx);
        @(negedge clk);
        in_valid = 1'b1;
        in_idx   = idx;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int gcnt, tcnt, maxh;

    initial begin
        // reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 1: grant on line 2, done three cycles later
        accept4(2'd2);
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        check("t1_hold0", 32'(hold_cnt), 32'd0);
        wait_cycles(3);
        check("t1_hold3", 32'(hold_cnt), 32'd3);
        done = 4'b0100;
        @(negedge clk);
        done = 4'b0000;
        check("t1_release_grant", 32'(grant), 32'd0);
        check("t1_release_ready", 32'(in_ready), 32'd0);
        check("t1_release_no_to", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("t1_idle_ready", 32'(in_ready), 32'd1);

        // 2: line 1 with no done -> exactly TIMEOUT grant cycles
        accept4(2'd1);
        gcnt = 0; tcnt = 0; maxh = 0;
        for (int i = 0; i < 30; i++) begin
            if (grant == 4'b0010) gcnt++;
            if (timeout_err) tcnt++;
            if (int'(hold_cnt) > maxh) maxh = int'(hold_cnt);
            @(negedge clk);
        end
        check("t2_grant_cycles", 32'(gcnt), 32'd16);
        check("t2_timeout_pulses", 32'(tcnt), 32'd1);
        check("t2_hold_max", 32'(maxh), 32'd15);

        // 3: line 3 while other done lines toggle
        accept4(2'd3);
        for (int i = 0; i < 10; i++) begin
            done = 4'($urandom_range(0, 7));
            @(negedge clk);
            check("t3_grant_held", 32'(grant), 32'h8);
        end
        done = 4'b1000;
        @(negedge clk);
        done = 4'b0000;
        check("t3_released", 32'(grant), 32'd0);
        check("t3_no_to", 32'(timeout_err), 32'd0);
        @(negedge clk);

        // 4: done on the last hold cycle beats the timer
        accept4(2'd0);
        wait_cycles(15);
        check("t4_hold15", 32'(hold_cnt), 32'd15);
        done = 4'b0001;
        @(negedge clk);
        done = 4'b0000;
        check("t4_grant", 32'(grant), 32'd0);
        check("t4_no_to", 32'(timeout_err), 32'd0);
        check("t4_busy_release", 32'(busy), 32'd1);
        @(negedge clk);

        // 5: N=5 instance, out-of-range index, then index 4
        @(negedge clk);
        valid5 = 1'b1;
        idx5   = 3'd6;
        @(negedge clk);
        valid5 = 1'b0;
        check("t5_bad_pulse", 32'(bad5), 32'd1);
        check("t5_no_grant", 32'(grant5), 32'd0);
        check("t5_ready", 32'(ready5), 32'd1);
        @(negedge clk);
        check("t5_bad_clear", 32'(bad5), 32'd0);
        valid5 = 1'b1;
        idx5   = 3'd4;
        @(negedge clk);
        valid5 = 1'b0;
        check("t5_grant4", 32'(grant5), 32'h10);
        done5 = 5'b10000;
        @(negedge clk);
        done5 = 5'b00000;
        check("t5_grant4_released", 32'(grant5), 32'd0);
        @(negedge clk);

        // 6: reset mid-grant
        accept4(2'd0);
        check("t6_grant", 32'(grant), 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_to", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept4(2'd2);
        check("t6_reaccept", 32'(grant), 32'h4);
        done = 4'b0100;
        @(negedge clk);
        done = 4'b0000;
        wait_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
